// File: rtl/sprite_sdr_reader.sv
// Sprite ROM fetch responder: turns a 64-bit fetch request into a 4-beat x16 SDRAM burst,
// with a one-entry last-address cache and a sticky timeout error.
module sprite_sdr_reader #(
  parameter int unsigned CACHE_EN = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK_96M,
  input  logic        reset,
  input  logic        sdr_req,
  input  logic [23:0] sdr_addr,
  output logic [63:0] sdr_data,
  output logic        sdr_rdy,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_dout,
  input  logic        mem_dvalid,
  input  logic        cache_inv,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COLLECT, S_DONE} state_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t      state_q;
  logic        pending_q;
  logic        valid_q;
  logic [23:0] pend_addr_q;
  logic [23:0] tag_q;
  logic [23:0] mem_addr_q;
  logic [63:0] data_q;
  logic [1:0]  cnt_q;
  logic [7:0]  tmo_q;
  logic        mem_req_q;
  logic        err_q;

  logic [23:0] req_addr;
  logic [23:0] start_addr;
  logic        hit;
  logic        busy;
  logic        abort;

  assign req_addr   = {sdr_addr[23:2], 2'b00};
  // A fresh strobe in IDLE takes priority over a pending (older) request.
  assign start_addr = sdr_req ? req_addr : pend_addr_q;
  assign hit        = (CACHE_EN != 0) && valid_q && !cache_inv && (start_addr == tag_q);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_COLLECT);
  assign abort      = busy && (tmo_q == TMO_LIM);

  assign sdr_rdy  = (state_q == S_IDLE) && !sdr_req && !pending_q;
  assign sdr_data = data_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign err      = err_q;

  always_ff @(posedge CLK_96M) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      pend_addr_q <= '0;
      tag_q       <= '0;
      mem_addr_q  <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (abort) begin
        mem_req_q <= 1'b0;
        err_q     <= 1'b1;
        valid_q   <= 1'b0;
        state_q   <= S_DONE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (sdr_req || pending_q) begin
              pending_q <= 1'b0;
              if (hit) begin
                state_q <= S_DONE;
              end else begin
                mem_addr_q <= start_addr;
                mem_req_q  <= 1'b1;
                tmo_q      <= '0;
                cnt_q      <= '0;
                state_q    <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            tmo_q <= tmo_q + 8'd1;
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            tmo_q <= tmo_q + 8'd1;
            if (mem_dvalid) begin
              data_q[{cnt_q, 4'b0000} +: 16] <= mem_dout;
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                tag_q   <= mem_addr_q;
                valid_q <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end

      // Requests arriving while busy are queued; the newest address overwrites older ones.
      if (state_q != S_IDLE && sdr_req) begin
        pending_q   <= 1'b1;
        pend_addr_q <= req_addr;
      end

      if (cache_inv) valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_sdr_reader.sv
// Directed bench for sprite_sdr_reader: miss, hit, invalidate, alignment, queued request,
// timeout and mid-burst reset.
module tb_sprite_sdr_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sdr_req = 1'b0;
  logic [23:0] sdr_addr = '0;
  logic [63:0] sdr_data;
  logic        sdr_rdy;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        mem_dvalid = 1'b0;
  logic        cache_inv = 1'b0;
  logic        err;

  int total = 0;
  int bad   = 0;

  sprite_sdr_reader #(.CACHE_EN(1), .TIMEOUT(255)) dut (
    .CLK_96M    (clk),
    .reset      (reset),
    .sdr_req    (sdr_req),
    .sdr_addr   (sdr_addr),
    .sdr_data   (sdr_data),
    .sdr_rdy    (sdr_rdy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_dout   (mem_dout),
    .mem_dvalid (mem_dvalid),
    .cache_inv  (cache_inv),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic [23:0] addr);
    sdr_req  = 1'b1;
    sdr_addr = addr;
    #1;
    chk({tag, "_rdy_in_req"}, 64'(sdr_rdy), 64'd0);
    tick();
    sdr_req = 1'b0;
  endtask

  task automatic pulse_inv();
    cache_inv = 1'b1;
    tick();
    cache_inv = 1'b0;
  endtask

  task automatic give_beat(input int gap, input logic [15:0] d);
    repeat (gap) tick();
    mem_dout   = d;
    mem_dvalid = 1'b1;
    tick();
    mem_dvalid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_mem_req_seen"}, 64'(mem_req), 64'd1);
  endtask

  task automatic do_ack(input string tag, input int dly);
    repeat (dly) tick();
    chk({tag, "_req_held"}, 64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_req_drop"}, 64'(mem_req), 64'd0);
  endtask

  // Full burst service; checks rdy timing and assembled data at the end.
  task automatic serve(input string tag, input logic [23:0] exp_addr, input int gap,
                       input logic [63:0] beats);
    wait_req(tag);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
    do_ack(tag, 2);
    for (int k = 0; k < 4; k++) give_beat(gap, beats[16*k +: 16]);
    chk({tag, "_rdy_done"}, 64'(sdr_rdy), 64'd0);
    chk({tag, "_data"}, sdr_data, beats);
    tick();
    chk({tag, "_rdy_back"}, 64'(sdr_rdy), 64'd1);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_rdy", 64'(sdr_rdy), 64'd1);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", sdr_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // Miss
    do_req("miss", 24'h10_0004);
    chk("miss_rdy_issue", 64'(sdr_rdy), 64'd0);
    serve("miss", 24'h10_0004, 0, 64'h4444_3333_2222_1111);

    // Hit: no SDRAM access, rdy back at N+2
    do_req("hit", 24'h10_0004);
    chk("hit_rdy_n1", 64'(sdr_rdy), 64'd0);
    chk("hit_no_req_n1", 64'(mem_req), 64'd0);
    tick();
    chk("hit_rdy_n2", 64'(sdr_rdy), 64'd1);
    chk("hit_no_req_n2", 64'(mem_req), 64'd0);
    chk("hit_data", sdr_data, 64'h4444_3333_2222_1111);

    // Invalidate, then the same address misses again
    pulse_inv();
    do_req("inv", 24'h10_0004);
    serve("inv", 24'h10_0004, 0, 64'h8888_7777_6666_5555);

    // Alignment and gapped beats
    pulse_inv();
    do_req("align", 24'h10_0006);
    serve("align", 24'h10_0004, 2, 64'hDDDD_CCCC_BBBB_AAAA);

    // Request queued during COLLECT is serviced without a new strobe
    do_req("b2b", 24'h30_0008);
    wait_req("b2b");
    chk("b2b_mem_addr1", 64'(mem_addr), 64'h30_0008);
    do_ack("b2b", 1);
    give_beat(0, 16'h0101);
    give_beat(0, 16'h0202);
    sdr_req  = 1'b1;
    sdr_addr = 24'h20_0000;
    #1;
    chk("b2b_rdy_busy_req", 64'(sdr_rdy), 64'd0);
    tick();
    sdr_req = 1'b0;
    give_beat(0, 16'h0303);
    give_beat(0, 16'h0404);
    chk("b2b_data1", sdr_data, 64'h0404_0303_0202_0101);
    chk("b2b_rdy_done", 64'(sdr_rdy), 64'd0);
    tick();
    chk("b2b_rdy_pending", 64'(sdr_rdy), 64'd0);
    serve("b2b2", 24'h20_0000, 1, 64'h0808_0707_0606_0505);

    // Timeout: controller never acks
    do_req("tmo", 24'h40_0000);
    begin
      int n = 0;
      while (mem_req && n < 300) begin
        tick();
        n++;
      end
      chk("tmo_req_dropped", 64'(mem_req), 64'd0);
      chk("tmo_window", 64'(n >= 255 && n <= 256), 64'd1);
    end
    chk("tmo_err", 64'(err), 64'd1);
    tick();
    chk("tmo_rdy", 64'(sdr_rdy), 64'd1);
    chk("tmo_data_kept", sdr_data, 64'h0808_0707_0606_0505);
    // Previously cached line must miss after the abort
    do_req("post_tmo", 24'h20_0000);
    chk("post_tmo_miss", 64'(mem_req), 64'd1);
    serve("post_tmo", 24'h20_0000, 0, 64'h1234_5678_9ABC_DEF0);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset mid-burst, then stray beats
    pulse_inv();
    do_req("rstb", 24'h50_0000);
    wait_req("rstb");
    do_ack("rstb", 1);
    give_beat(0, 16'hAAAA);
    give_beat(0, 16'hBBBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstb_rdy", 64'(sdr_rdy), 64'd1);
    give_beat(0, 16'hDEAD);
    give_beat(0, 16'hBEEF);
    chk("rstb_data", sdr_data, 64'd0);
    chk("rstb_rdy_after", 64'(sdr_rdy), 64'd1);
    chk("rstb_mem_req", 64'(mem_req), 64'd0);
    chk("rstb_err", 64'(err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
